ibuf_skew_ctrl: RTL

IBUF_SKEW_CTRL -- requirements
Module: ibuf_skew_ctrl

---
 rtl/systola_pkg.sv | 15 +
 rtl/ibuf_row_gate.sv | 61 ++++++
 rtl/ibuf_skew_ctrl.sv | 132 +++++++++++++
 3 files changed

// File: rtl/systola_pkg.sv
// Shared types and default widths for the systolic input-buffer skew controller.
package systola_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam int DEF_DW    = 8;
  localparam int DEF_LEN_W = 8;
  localparam int MIN_ROWS  = 2;
  localparam int MAX_ROWS  = 16;

endpackage

// File: rtl/ibuf_row_gate.sv
// One row of the skew triangle: decides whether the row is due in step t and
// registers the row's data/valid toward the systolic array.
module ibuf_row_gate
  import systola_pkg::*;
#(
  parameter int ROW   = 0,
  parameter int DW    = DEF_DW,
  parameter int LEN_W = DEF_LEN_W
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [LEN_W+3:0] t,
  input  logic [LEN_W-1:0] len,
  input  logic             rd,
  input  logic             fill,
  input  logic [DW-1:0]    din,
  output logic             due,
  output logic [DW-1:0]    dout,
  output logic             dvalid
);

  localparam int CW = LEN_W + 5;

  logic [CW-1:0] t_w;
  logic [CW-1:0] lo_w;
  logic [CW-1:0] hi_w;
  logic [DW-1:0] dout_q, dout_d;
  logic          dvalid_q, dvalid_d;

  // One extra bit over t so ROW+len never wraps at the largest len.
  assign t_w  = CW'(t);
  assign lo_w = CW'(ROW);
  assign hi_w = lo_w + CW'(len);
  assign due  = (t_w >= lo_w) && (t_w < hi_w);

  always_comb begin
    dout_d   = dout_q;
    dvalid_d = 1'b0;
    if (rd) begin
      dout_d   = din;
      dvalid_d = 1'b1;
    end else if (fill) begin
      dout_d   = '0;
      dvalid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dout_q   <= '0;
      dvalid_q <= 1'b0;
    end else begin
      dout_q   <= dout_d;
      dvalid_q <= dvalid_d;
    end
  end

  assign dout   = dout_q;
  assign dvalid = dvalid_q;

endmodule

// File: rtl/ibuf_skew_ctrl.sv
// Drains ROWS input buffers into a systolic array with a one-cycle-per-row skew.
// Optional macro SKEW_ZERO_FILL_EN: zero-pads non-due rows with dvalid=1.
module ibuf_skew_ctrl
  import systola_pkg::*;
#(
  parameter int ROWS  = 4,
  parameter int DW    = DEF_DW,
  parameter int LEN_W = DEF_LEN_W
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    start,
  input  logic [LEN_W-1:0]        len,
  input  logic [ROWS-1:0]         empty,
  input  logic [ROWS-1:0][DW-1:0] din,
  output logic [ROWS-1:0]         read,
  output logic [ROWS-1:0][DW-1:0] dout,
  output logic [ROWS-1:0]         dvalid,
  output logic                    busy,
  output logic                    done
);

  localparam int TW = LEN_W + 4;
  localparam int CW = LEN_W + 5;

  state_e           state_q, state_d;
  logic [TW-1:0]    t_q, t_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [ROWS-1:0]  due;
  logic [ROWS-1:0]  fill;
  logic             run;
  logic             stall;
  logic             advance;
  logic [CW-1:0]    last_t;
  logic             last_step;

  // A due row with an empty buffer freezes the whole wavefront.
  assign run       = (state_q == ST_RUN);
  assign stall     = run && |(due & empty);
  assign advance   = run && !stall;
  assign last_t    = CW'(len_q) + CW'(ROWS - 2);
  assign last_step = (CW'(t_q) == last_t);
  assign read      = advance ? due : '0;

`ifdef SKEW_ZERO_FILL_EN
  assign fill = advance ? ~due : '0;
`else
  assign fill = '0;
`endif

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    len_d   = len_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          len_d = len;
          if (len != '0) begin
            state_d = ST_RUN;
            t_d     = '0;
            busy_d  = 1'b1;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (advance) begin
          if (last_step) begin
            state_d = ST_DRAIN;
            done_d  = 1'b1;
          end else begin
            t_d = t_q + 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      t_q     <= '0;
      len_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      len_q   <= len_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    ibuf_row_gate #(
      .ROW  (r),
      .DW   (DW),
      .LEN_W(LEN_W)
    ) u_row (
      .clk   (clk),
      .rstn  (rstn),
      .t     (t_q),
      .len   (len_q),
      .rd    (read[r]),
      .fill  (fill[r]),
      .din   (din[r]),
      .due   (due[r]),
      .dout  (dout[r]),
      .dvalid(dvalid[r])
    );
  end

endmodule
